// File: rtl/nes_video_pkg.sv
// Shared NES video-path types and constants: colour code / RGB widths,
// scanline length, palette size and the line-replay FSM state type.
package nes_video_pkg;

  localparam int COLOUR_W         = 6;
  localparam int RGB_W            = 9;
  localparam int NES_LINE_LEN     = 256;
  localparam int NES_PALETTE_SIZE = 64;

  typedef logic [COLOUR_W-1:0] colour_code_t;
  typedef logic [RGB_W-1:0]    rgb_t;

  // FIRST: first emission of a line; REPLAY: re-emitting a held line
  typedef enum logic {
    FIRST  = 1'b0,
    REPLAY = 1'b1
  } replay_state_t;

endpackage

// File: rtl/nes_palette_rom.sv
// 64 x 9-bit synchronous palette ROM mapping NES colour codes to RGB333.
// Only present when NES_LINE_FIFO_PALETTE_EN is defined; otherwise colour
// decode happens downstream and this module does not exist.
`ifdef NES_LINE_FIFO_PALETTE_EN
module nes_palette_rom
  import nes_video_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  colour_code_t addr,
  output rgb_t         rgb
);

  function automatic rgb_t palette_lookup(input colour_code_t code);
    case (code)
      6'h00: palette_lookup = 9'o333;
      6'h01: palette_lookup = 9'o007;
      6'h02: palette_lookup = 9'o005;
      6'h03: palette_lookup = 9'o215;
      6'h04: palette_lookup = 9'o404;
      6'h05: palette_lookup = 9'o501;
      6'h06: palette_lookup = 9'o500;
      6'h07: palette_lookup = 9'o400;
      6'h08: palette_lookup = 9'o210;
      6'h09: palette_lookup = 9'o030;
      6'h0A: palette_lookup = 9'o030;
      6'h0B: palette_lookup = 9'o020;
      6'h0C: palette_lookup = 9'o022;
      6'h10: palette_lookup = 9'o555;
      6'h11: palette_lookup = 9'o037;
      6'h12: palette_lookup = 9'o027;
      6'h13: palette_lookup = 9'o327;
      6'h14: palette_lookup = 9'o606;
      6'h15: palette_lookup = 9'o702;
      6'h16: palette_lookup = 9'o710;
      6'h17: palette_lookup = 9'o720;
      6'h18: palette_lookup = 9'o530;
      6'h19: palette_lookup = 9'o050;
      6'h1A: palette_lookup = 9'o050;
      6'h1B: palette_lookup = 9'o052;
      6'h1C: palette_lookup = 9'o044;
      6'h20: palette_lookup = 9'o777;
      6'h21: palette_lookup = 9'o157;
      6'h22: palette_lookup = 9'o347;
      6'h23: palette_lookup = 9'o437;
      6'h24: palette_lookup = 9'o737;
      6'h25: palette_lookup = 9'o724;
      6'h26: palette_lookup = 9'o732;
      6'h27: palette_lookup = 9'o752;
      6'h28: palette_lookup = 9'o750;
      6'h29: palette_lookup = 9'o570;
      6'h2A: palette_lookup = 9'o262;
      6'h2B: palette_lookup = 9'o274;
      6'h2C: palette_lookup = 9'o076;
      6'h2D: palette_lookup = 9'o333;
      6'h30: palette_lookup = 9'o777;
      6'h31: palette_lookup = 9'o577;
      6'h32: palette_lookup = 9'o557;
      6'h33: palette_lookup = 9'o657;
      6'h34: palette_lookup = 9'o757;
      6'h35: palette_lookup = 9'o756;
      6'h36: palette_lookup = 9'o765;
      6'h37: palette_lookup = 9'o775;
      6'h38: palette_lookup = 9'o763;
      6'h39: palette_lookup = 9'o673;
      6'h3A: palette_lookup = 9'o575;
      6'h3B: palette_lookup = 9'o576;
      6'h3C: palette_lookup = 9'o077;
      6'h3D: palette_lookup = 9'o767;
      default: palette_lookup = 9'o000;
    endcase
  endfunction

  // Registered lookup, updated only when a code is actually popped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= '0;
    end else if (en) begin
      rgb <= palette_lookup(addr);
    end
  end

endmodule
`endif

// File: rtl/nes_line_repeat_fifo.sv
// Colour-code FIFO between the PPU pixel producer and the VGA output stage.
// Optionally re-emits each completed scanline REPEAT times (line doubling);
// a line's storage is released only after its final emission.
// Optional feature macro: NES_LINE_FIFO_PALETTE_EN adds rgb_out, the
// registered palette lookup of each popped code.
module nes_line_repeat_fifo
  import nes_video_pkg::*;
#(
  parameter int DATA_W   = COLOUR_W,
  parameter int DEPTH    = 512,
  parameter int LINE_LEN = NES_LINE_LEN,
  parameter int REPEAT   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     repeat_en,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     line_done,
  output logic                     overflow,
  output logic                     underflow
`ifdef NES_LINE_FIFO_PALETTE_EN
  ,
  output rgb_t                     rgb_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [LW-1:0] LINE_LAST = LW'(LINE_LEN - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT - 1);
  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] base_ptr;
  logic [PW-1:0] readable;

  logic [LW-1:0]  pix_cnt;
  logic [RW-1:0]  rep_cnt;
  replay_state_t  state;
  logic           rep_mode;

  logic              do_wr;
  logic              do_rd;
  logic              line_start;
  logic              cur_mode;
  logic              line_end;
  logic              replay;
  logic              release_line;
  logic              track;
  logic [DATA_W-1:0] rd_code;

  // Occupancy, flags and per-pop decisions, all from pre-edge state.
  // At the start of a fresh line the mode is taken straight from repeat_en,
  // so the first pop of the line already obeys the value being latched.
  always_comb begin
    readable     = wr_ptr - rd_ptr;
    level        = wr_ptr - base_ptr;
    empty        = (readable == '0);
    full         = (level == DEPTH_P);
    do_wr        = wr_en && !full;
    do_rd        = rd_en && !empty;
    line_start   = (state == FIRST) && (pix_cnt == '0);
    cur_mode     = line_start ? repeat_en : rep_mode;
    line_end     = (pix_cnt == LINE_LAST);
    replay       = do_rd && line_end && cur_mode && (rep_cnt != REP_LAST);
    release_line = do_rd && line_end && !replay;
    track        = do_rd && (!cur_mode || (REPEAT == 1));
    rd_code      = mem[rd_ptr[AW-1:0]];
  end

  // Storage array: data only, never reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Write, read and release pointers; a replay rewinds rd_ptr to the line start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      base_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_rd) begin
        rd_ptr <= replay ? base_ptr : rd_ptr + PW'(1);
      end
      if (release_line || track) begin
        base_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Replay FSM with pixel and repeat counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FIRST;
      pix_cnt  <= '0;
      rep_cnt  <= '0;
      rep_mode <= 1'b0;
    end else begin
      if (line_start) begin
        rep_mode <= repeat_en;
      end
      if (do_rd) begin
        if (line_end) begin
          pix_cnt <= '0;
          if (replay) begin
            rep_cnt <= rep_cnt + RW'(1);
            state   <= REPLAY;
          end else begin
            rep_cnt <= '0;
            state   <= FIRST;
          end
        end else begin
          pix_cnt <= pix_cnt + LW'(1);
        end
      end
    end
  end

  // Registered read port, line completion pulse and sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      line_done <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid  <= do_rd;
      line_done <= release_line;
      if (do_rd) begin
        rd_data <= rd_code;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef NES_LINE_FIFO_PALETTE_EN
  nes_palette_rom u_palette (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (do_rd),
    .addr    (colour_code_t'(rd_code)),
    .rgb     (rgb_out)
  );
`endif

endmodule

// File: tb/tb_nes_line_repeat_fifo.sv
// Self-checking bench for nes_line_repeat_fifo (DEPTH=8, LINE_LEN=4, REPEAT=2).
// A queue-based model of held lines predicts every output after each edge.
module tb_nes_line_repeat_fifo;

  localparam int DATA_W   = 6;
  localparam int DEPTH    = 8;
  localparam int LINE_LEN = 4;
  localparam int REPEAT   = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              repeat_en = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [3:0]        level;
  logic              line_done;
  logic              overflow;
  logic              underflow;
`ifdef NES_LINE_FIFO_PALETTE_EN
  logic [8:0]        rgb_out;
`endif

  nes_line_repeat_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .LINE_LEN (LINE_LEN),
    .REPEAT   (REPEAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .repeat_en (repeat_en),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .line_done (line_done),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef NES_LINE_FIFO_PALETTE_EN
    ,
    .rgb_out   (rgb_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: q holds every unreleased entry, oldest first;
  // rd_idx is the position within q of the next entry to emit.
  int unsigned q[$];
  int          rd_idx;
  int          line_pos;
  int          emission;
  bit          mode;
  int unsigned m_rd_data;
  bit          m_valid;
  bit          m_done;
  bit          m_ovf;
  bit          m_unf;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    rd_idx    = 0;
    line_pos  = 0;
    emission  = 0;
    mode      = 1'b0;
    m_rd_data = 0;
    m_valid   = 1'b0;
    m_done    = 1'b0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
  endtask

  task automatic model_edge(input bit w, input int d, input bit r, input bit rep);
    int sz;
    bit mfull;
    bit mempty;
    sz     = q.size();
    mfull  = (sz == DEPTH);
    mempty = (sz - rd_idx == 0);
    m_valid = 1'b0;
    m_done  = 1'b0;
    if (line_pos == 0 && emission == 0) mode = rep;
    if (w && mfull) m_ovf = 1'b1;
    if (r && mempty) m_unf = 1'b1;
    if (r && !mempty) begin
      m_rd_data = q[rd_idx];
      m_valid   = 1'b1;
      rd_idx++;
      line_pos++;
      if (line_pos == LINE_LEN) begin
        line_pos = 0;
        if (mode && emission < REPEAT - 1) begin
          emission++;
          rd_idx = 0;
        end else begin
          emission = 0;
          m_done   = 1'b1;
        end
      end
      if (!mode || REPEAT == 1 || m_done) begin
        for (int k = 0; k < rd_idx; k++) void'(q.pop_front());
        rd_idx = 0;
      end
    end
    if (w && !mfull) q.push_back(d);
  endtask

  task automatic check_all();
    check("level", level, q.size());
    check("empty", empty, (q.size() - rd_idx) == 0);
    check("full", full, q.size() == DEPTH);
    check("rd_valid", rd_valid, m_valid);
    if (m_valid) check("rd_data", rd_data, m_rd_data);
    check("line_done", line_done, m_done);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
  endtask

  task automatic step(input bit w, input int d, input bit r, input bit rep);
    wr_en     = w;
    wr_data   = d[DATA_W-1:0];
    rd_en     = r;
    repeat_en = rep;
    @(posedge clk);
    model_edge(w, d % (1 << DATA_W), r, rep);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("reset_rd_data", rd_data, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // Half-fill then reset: everything returns to the empty state
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
    check("half_level", level, 4);
    do_reset();
    step(1'b0, 0, 1'b0, 1'b0);
    check("post_reset_level", level, 0);
    check("post_reset_empty", empty, 1);

    // Plain FIFO: fill to full, overflow drop, drain in order
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    check("plain_full", full, 1);
    step(1'b1, 63, 1'b0, 1'b0);
    check("plain_overflow", overflow, 1);
    check("plain_level_after_drop", level, 8);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0, 1'b1, 1'b0);
      check("plain_data", rd_data, i + 1);
      check("plain_done", line_done, (i == 3 || i == 7));
    end
    step(1'b0, 0, 1'b0, 1'b0);
    do_reset();

    // Line replay: one line emitted twice, held until the last pop
    for (int i = 10; i <= 13; i++) step(1'b1, i, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0, 1'b1, 1'b1);
      check("rep_data", rd_data, 10 + (i % 4));
      check("rep_level", level, (i < 7) ? 4 : 0);
      check("rep_done", line_done, i == 7);
    end

    // Underflow on empty read
    step(1'b0, 0, 1'b1, 1'b1);
    check("unf_flag", underflow, 1);
    check("unf_valid", rd_valid, 0);
    check("unf_level", level, 0);
    do_reset();

    // Simultaneous push and pop at level 3
    for (int i = 20; i <= 22; i++) step(1'b1, i, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 30 + i, 1'b1, 1'b0);
      check("simul_level", level, 3);
      check("simul_data", rd_data, (i < 3) ? 20 + i : 30 + i - 3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
    check("simul_drained", empty, 1);
    do_reset();

    // repeat_en dropped mid-line: current line still doubled, next line once
    for (int i = 40; i <= 47; i++) step(1'b1, i, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 0, 1'b1, (i < 2));
      check("toggle_data", rd_data, (i < 8) ? 40 + (i % 4) : 44 + (i - 8));
      check("toggle_done", line_done, (i == 7 || i == 11));
    end
    check("toggle_level", level, 0);
    do_reset();

    // Randomised traffic in phases with different read/write pressure
    begin
      bit rep;
      rep = 1'b0;
      for (int ph = 0; ph < 3; ph++) begin
        for (int c = 0; c < 200; c++) begin
          int wp;
          int rp;
          wp = (ph == 0) ? 80 : (ph == 1) ? 40 : 60;
          rp = (ph == 0) ? 40 : (ph == 1) ? 80 : 60;
          if ($urandom_range(0, 19) == 0) rep = ~rep;
          step($urandom_range(0, 99) < wp, $urandom_range(0, 63),
               $urandom_range(0, 99) < rp, rep);
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
